tdoa_frame_sched: RTL

- Frame scheduler for the acoustic-camera delay-calculation engine.
- Starts one calculation per frame and collects the per-channel time-delay results (Td0..Td5) and the threshold flag.
- Packs each frame into one 32-bit word and hands it to the PS-side register reader over a valid/ack handshake.
- Replaces toggle-edge packing with a single-clock, fully synchronous sequencer.

---
 rtl/tdoa_frame_sched_if.sv | 34 +++
 rtl/tdoa_frame_sched.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tdoa_frame_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : tdoa_frame_sched_if
// Purpose  : Engine-side and reader-side signal bundle for tdoa_frame_sched.
// Revision : 1.0 - initial release
// ============================================================================
interface tdoa_frame_sched_if #(
    parameter int TD_W = 4
);
    logic            EN;
    logic            CALC_FREE;
    logic            CALC_START;
    logic            TD_VALID;
    logic [2:0]      TD_IDX;
    logic [TD_W-1:0] TD;
    logic            THRES;
    logic [31:0]     DATA;
    logic            DATA_VALID;
    logic            DATA_ACK;
    logic [7:0]      DROP_CNT;
    logic            TIMEOUT_ERR;

    // master drives the engine/reader side; slave is the scheduler itself
    modport master (
        output EN, CALC_FREE, TD_VALID, TD_IDX, TD, THRES, DATA_ACK,
        input  CALC_START, DATA, DATA_VALID, DROP_CNT, TIMEOUT_ERR
    );

    modport slave (
        input  EN, CALC_FREE, TD_VALID, TD_IDX, TD, THRES, DATA_ACK,
        output CALC_START, DATA, DATA_VALID, DROP_CNT, TIMEOUT_ERR
    );
endinterface
`default_nettype wire

// File: rtl/tdoa_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tdoa_frame_sched
// Purpose  : Per-frame sequencer: starts the delay engine, gathers Td beats,
//            packs them into one 32-bit word behind a valid/ack register.
// Revision : 1.0 - initial release
// ============================================================================
module tdoa_frame_sched #(
    parameter int N_CH    = 6,
    parameter int TD_W    = 4,
    parameter int TIMEOUT = 1023
) (
    input  wire logic         SCK,
    input  wire logic         RST,
    tdoa_frame_sched_if.slave bus
);
    localparam int c_TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_START   = 2'd1;
    localparam logic [1:0] c_ST_COLLECT = 2'd2;
    localparam logic [1:0] c_ST_PACK    = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_TMR_W-1:0] r_timer;
    logic [N_CH-1:0]    r_mask;
    logic [TD_W-1:0]    r_stage [N_CH];
    logic               r_thres;
    logic [6:0]         r_seq;
    logic [31:0]        r_data;
    logic               r_data_valid;
    logic [7:0]         r_drop_cnt;
    logic               r_timeout_err;

    logic               w_st_start;
    logic               w_st_collect;
    logic               w_st_pack;
    logic               w_calc_start;
    logic               w_timeout;
    logic               w_beat;
    logic               w_mask_full;
    logic               w_timer_exp;
    logic [31:0]        w_word;

    assign w_beat      = w_st_collect && bus.TD_VALID && (bus.TD_IDX < 3'(N_CH));
    assign w_mask_full = &r_mask;
    assign w_timer_exp = (r_timer == c_TMR_W'(TIMEOUT - 1));

    always_ff @(posedge SCK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Completion wins over timeout when both land on the same cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.EN && bus.CALC_FREE) begin
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                w_state_nxt = c_ST_COLLECT;
            end
            c_ST_COLLECT: begin
                if (w_mask_full && bus.CALC_FREE) begin
                    w_state_nxt = c_ST_PACK;
                end else if (w_timer_exp) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_PACK: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_st_start   = (r_state == c_ST_START);
        w_st_collect = (r_state == c_ST_COLLECT);
        w_st_pack    = (r_state == c_ST_PACK);
        w_calc_start = w_st_start;
        w_timeout    = w_st_collect && !(w_mask_full && bus.CALC_FREE) && w_timer_exp;
    end

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            always_ff @(posedge SCK) begin
                if (RST) begin
                    r_mask[g]  <= 1'b0;
                    r_stage[g] <= '0;
                end else if (w_st_start) begin
                    r_mask[g]  <= 1'b0;
                end else if (w_beat && (bus.TD_IDX == 3'(g))) begin
                    r_mask[g]  <= 1'b1;
                    r_stage[g] <= bus.TD;
                end
            end
        end
    endgenerate

    always_comb begin
        w_word = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_word[4*i +: TD_W] = r_stage[i];
        end
        w_word[24]    = r_thres;
        w_word[31:25] = r_seq;
    end

    always_ff @(posedge SCK) begin
        if (RST) begin
            r_timer       <= '0;
            r_thres       <= 1'b0;
            r_seq         <= '0;
            r_data        <= '0;
            r_data_valid  <= 1'b0;
            r_drop_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_st_start) begin
                r_timer <= '0;
            end else if (w_st_collect) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_beat) begin
                r_thres <= bus.THRES;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            // Sequence advances even on a drop so the reader can detect gaps
            if (w_st_pack) begin
                r_seq <= r_seq + 7'd1;
                if (!r_data_valid || bus.DATA_ACK) begin
                    r_data       <= w_word;
                    r_data_valid <= 1'b1;
                end else if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end else if (r_data_valid && bus.DATA_ACK) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign bus.CALC_START  = w_calc_start;
    assign bus.DATA        = r_data;
    assign bus.DATA_VALID  = r_data_valid;
    assign bus.DROP_CNT    = r_drop_cnt;
    assign bus.TIMEOUT_ERR = r_timeout_err;

endmodule
`default_nettype wire
